// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: parametrised IEEE-754 multiplier, 3-stage pipeline (unpack, multiply, round/pack).
// Define FP_MULT_TAG_EN to add the in_tag/out_tag sideband that travels with each operation.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
`ifdef FP_MULT_TAG_EN
    ,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [TAG_W-1:0]       out_tag
`endif
);

    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned EW = EXP_W + 2;
    localparam logic signed [EW-1:0] Bias   = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] ExpMax = EW'((2 ** EXP_W) - 1);

    if (TAG_W == 0 || EXP_W < 2 || MAN_W < 2) begin : g_param_check
        $error("fp_mult_pipe: EXP_W, MAN_W must be >= 2 and TAG_W >= 1");
    end

    typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} special_e;

    // Global enable: a held result freezes every stage behind it.
    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    // ---------------- Stage 1: unpack / classify ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             inf_times_zero;
    special_e         spec_d;
    logic             inv_d;
    logic signed [EW-1:0] esum_d;

    assign ea = a[EXP_W+MAN_W-1:MAN_W];
    assign eb = b[EXP_W+MAN_W-1:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    // Subnormals are flushed: a zero exponent field always classifies as zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & (ma == '0);
    assign b_inf  = (&eb) & (mb == '0);
    assign a_nan  = (&ea) & (ma != '0);
    assign b_nan  = (&eb) & (mb != '0);
    assign a_snan = a_nan & ~ma[MAN_W-1];
    assign b_snan = b_nan & ~mb[MAN_W-1];
    assign inf_times_zero = (a_inf & b_zero) | (b_inf & a_zero);

    assign esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;

    always_comb begin
        spec_d = SpNone;
        inv_d  = 1'b0;
        if (a_nan | b_nan | inf_times_zero) begin
            spec_d = SpNan;
            inv_d  = a_snan | b_snan | inf_times_zero;
        end else if (a_inf | b_inf) begin
            spec_d = SpInf;
        end else if (a_zero | b_zero) begin
            spec_d = SpZero;
        end
    end

    logic                 s1_valid_q, s1_sign_q, s1_inv_q;
    special_e             s1_spec_q;
    logic [SW-1:0]        s1_sig_a_q, s1_sig_b_q;
    logic signed [EW-1:0] s1_esum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_spec_q  <= SpNone;
            s1_sig_a_q <= '0;
            s1_sig_b_q <= '0;
            s1_esum_q  <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q  <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                s1_inv_q   <= inv_d;
                s1_spec_q  <= spec_d;
                s1_sig_a_q <= {1'b1, ma};
                s1_sig_b_q <= {1'b1, mb};
                s1_esum_q  <= esum_d;
            end
        end
    end

    // ---------------- Stage 2: significand multiply ----------------
    logic                 s2_valid_q, s2_sign_q, s2_inv_q;
    special_e             s2_spec_q;
    logic [PW-1:0]        s2_prod_q;
    logic signed [EW-1:0] s2_esum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_spec_q  <= SpNone;
            s2_prod_q  <= '0;
            s2_esum_q  <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_inv_q  <= s1_inv_q;
                s2_spec_q <= s1_spec_q;
                s2_prod_q <= PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
                s2_esum_q <= s1_esum_q;
            end
        end
    end

    // ---------------- Stage 3: normalise / round / pack ----------------
    logic [PW-1:0]        norm;
    logic [SW-1:0]        sig_n;
    logic                 guard, sticky, round_up;
    logic [SW:0]          rounded;
    logic signed [EW-1:0] exp_f;
    logic [EXP_W+MAN_W:0] res_d;
    logic [3:0]           flags_d;

    always_comb begin
        norm     = s2_prod_q[PW-1] ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
        sig_n    = norm[PW-1:MAN_W+1];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | sig_n[0]);
        rounded  = {1'b0, sig_n} + {{SW{1'b0}}, round_up};
        // A rounding carry leaves the mantissa field all-zero, so only the exponent moves.
        exp_f    = s2_esum_q + $signed(EW'(s2_prod_q[PW-1])) + $signed(EW'(rounded[SW]));
        res_d    = {s2_sign_q, exp_f[EXP_W-1:0], rounded[MAN_W-1:0]};
        flags_d  = {3'b000, guard | sticky};
        unique case (s2_spec_q)
            SpNan: begin
                res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flags_d = {s2_inv_q, 3'b000};
            end
            SpInf: begin
                res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_d = 4'b0000;
            end
            SpZero: begin
                res_d   = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
                flags_d = 4'b0000;
            end
            default: begin
                if (exp_f >= ExpMax) begin
                    res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (exp_f[EW-1] || exp_f == '0) begin
                    res_d   = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
                    flags_d = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            out_valid <= s2_valid_q;
            if (s2_valid_q) begin
                result <= res_d;
                flags  <= flags_d;
            end
        end
    end

`ifdef FP_MULT_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_tag_q <= '0;
            s2_tag_q <= '0;
            out_tag  <= '0;
        end else if (en) begin
            if (in_valid)   s1_tag_q <= in_tag;
            if (s1_valid_q) s2_tag_q <= s1_tag_q;
            if (s2_valid_q) out_tag  <= s2_tag_q;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (binary32), with an arithmetic reference model.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
`ifdef FP_MULT_TAG_EN
    logic [3:0]  in_tag, out_tag;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];  // {tag, flags, result}

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
`ifdef FP_MULT_TAG_EN
        ,
        .in_tag    (in_tag),
        .out_tag   (out_tag)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    localparam int NDIR = 12;
    logic [31:0] dir_a [NDIR] = '{32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                                  32'h00800000, 32'h7F800000, 32'h7FA00000, 32'hFF800000,
                                  32'h7FC00001, 32'h00000001, 32'h3F800001, 32'h3F800003};
    logic [31:0] dir_b [NDIR] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h40000000,
                                  32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000,
                                  32'h40000000, 32'h40000000, 32'h3FC00000, 32'h3FC00000};
    logic [31:0] dir_r [NDIR] = '{32'h40400000, 32'h3F800002, 32'h40000000, 32'h7F800000,
                                  32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                                  32'h7FC00000, 32'h00000000, 32'h3FC00002, 32'h3FC00004};
    logic [3:0]  dir_f [NDIR] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b1000,
                                  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};

    // Reference: exact integer product, then round-to-nearest-even by remainder comparison.
    function automatic logic [35:0] fp_model(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, e, msb, sh;
        logic s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, inv;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s = x[31] ^ y[31];
        x_zero = (ex == 0);
        y_zero = (ey == 0);
        x_inf = (ex == 255) && (x[22:0] == 0);
        y_inf = (ey == 255) && (y[22:0] == 0);
        x_nan = (ex == 255) && (x[22:0] != 0);
        y_nan = (ey == 255) && (y[22:0] != 0);
        inv = (x_nan && !x[22]) || (y_nan && !y[22]) || (x_inf && y_zero) || (y_inf && x_zero);
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
            return {inv, 3'b000, 32'h7FC00000};
        if (x_inf || y_inf) return {4'b0000, s, 8'hFF, 23'h0};
        if (x_zero || y_zero) return {4'b0000, s, 31'h0};
        p = 64'(x[22:0]) + (64'd1 << 23);
        q = 64'(y[22:0]) + (64'd1 << 23);
        p = p * q;
        msb = 0;
        for (int i = 0; i < 64; i++) if (p[i]) msb = i;
        sh = msb - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ex + ey - 127 + (msb - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, rem != 0, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
            end
            2: v[30:23] = 8'($urandom_range(190, 254));
            3: v[30:23] = 8'($urandom_range(1, 64));
            4: v[22:0] = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(96, 158));
        endcase
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] itag, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
`ifdef FP_MULT_TAG_EN
        in_tag = itag;
`else
        if (itag != itag) a = ia;
`endif
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_vec++;
        if (result !== 32'h0 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%b expected 00000000/0000", result, flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready %b out_valid %b expected 1 0", in_ready,
                     out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0] seen;
        for (int i = 0; i < NDIR; i++) begin
            drive(1'b1, dir_a[i], dir_b[i], 4'(i), 1'b1);
            seen = 3'b000;
            for (int c = 1; c <= 3; c++) begin
                drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
                seen = {seen[1:0], out_valid};
            end
            n_vec++;
            if (seen !== 3'b001) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: out_valid cycles1-3 %b expected 001", i, seen);
            end
            n_vec++;
            if (result !== dir_r[i]) begin
                n_err++;
                $display("FAIL directed_result[%0d]: %h*%h got %h expected %h", i, dir_a[i],
                         dir_b[i], result, dir_r[i]);
            end
            n_vec++;
            if (flags !== dir_f[i]) begin
                n_err++;
                $display("FAIL directed_flags[%0d]: got %b expected %b", i, flags, dir_f[i]);
            end
`ifdef FP_MULT_TAG_EN
            n_vec++;
            if (out_tag !== 4'(i)) begin
                n_err++;
                $display("FAIL directed_tag[%0d]: got %0d expected %0d", i, out_tag, i);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa[8], ob[8];
        logic [39:0] e;
        logic        ordy, iv;
        int          k = 0;
        int          got = 0;
        for (int i = 0; i < 8; i++) begin
            oa[i] = rand_op();
            ob[i] = rand_op();
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            iv   = (k < 8);
            ordy = !(cyc >= 4 && cyc <= 6);
            drive(iv, oa[k < 8 ? k : 0], ob[k < 8 ? k : 0], 4'(k), ordy);
            n_vec++;
            if (in_ready !== ordy) begin
                n_err++;
                $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, ordy);
            end
            n_vec++;
            if (out_valid !== (cyc >= 3 && cyc <= 13)) begin
                n_err++;
                $display("FAIL b2b_out_valid cyc %0d: got %b expected %b", cyc, out_valid,
                         (cyc >= 3 && cyc <= 13));
            end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                n_vec++;
                if ({flags, result} !== e[35:0]) begin
                    n_err++;
                    $display("FAIL b2b_data cyc %0d: got %b/%h expected %b/%h", cyc, flags,
                             result, e[35:32], e[31:0]);
                end
`ifdef FP_MULT_TAG_EN
                n_vec++;
                if (out_tag !== e[39:36]) begin
                    n_err++;
                    $display("FAIL b2b_tag cyc %0d: got %0d expected %0d", cyc, out_tag, e[39:36]);
                end
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(k), fp_model(oa[k], ob[k])});
                k++;
            end
        end
        n_vec++;
        if (got != 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results expected 8 (left %0d)", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [39:0] e;
        logic [31:0] ra, rb;
        logic        iv, ordy;
        int          tag = 0;
        for (int cyc = 0; cyc < 360; cyc++) begin
            ra   = rand_op();
            rb   = rand_op();
            iv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
            ordy = (cyc >= 300) || ($urandom_range(0, 3) != 0);
            drive(iv, ra, rb, 4'(tag), ordy);
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL random_extra: unexpected result %h", result);
                end else begin
                    e = exp_q.pop_front();
                    if ({flags, result} !== e[35:0]) begin
                        n_err++;
                        $display("FAIL random_data: got %b/%h expected %b/%h", flags, result,
                                 e[35:32], e[31:0]);
                    end
`ifdef FP_MULT_TAG_EN
                    n_vec++;
                    if (out_tag !== e[39:36]) begin
                        n_err++;
                        $display("FAIL random_tag: got %0d expected %0d", out_tag, e[39:36]);
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(tag), fp_model(ra, rb)});
                tag++;
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: %0d results never arrived, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        logic [2:0] seen;
        logic       any;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h3FC00000, 32'h40000000, 4'(i), 1'b1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL inflight_pre: out_valid %b expected 1", out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL inflight_async: got %b %h %b expected 0 00000000 0000", out_valid,
                     result, flags);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        any = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            any = any | out_valid;
        end
        n_vec++;
        if (any !== 1'b0) begin
            n_err++;
            $display("FAIL inflight_stale: out_valid seen %b expected 0", any);
        end
        drive(1'b1, 32'h3F800001, 32'h3F800001, 4'h9, 1'b1);
        seen = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            seen = {seen[1:0], out_valid};
        end
        n_vec++;
        if (seen !== 3'b001 || result !== 32'h3F800002 || flags !== 4'b0001) begin
            n_err++;
            $display("FAIL inflight_next: valid %b res %h flags %b expected 001 3F800002 0001",
                     seen, result, flags);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        out_ready = 1'b1;
`ifdef FP_MULT_TAG_EN
        in_tag = 4'h0;
`endif
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
